fpu_issue_arb: RTL

//  Shares one FP16 FMA pipeline (fpu1 -> fpu2 -> fpu3, 2 register stages) among NREQ requesters.

---
 rtl/fpu_issue_arb.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/fpu_issue_arb.sv
// Round-robin issue of NREQ requesters into one shared FP16 FMA pipeline. A tag pipe
// steers each result into its owner's response FIFO, and per-requester credits prevent overflow.

module fpu_issue_arb_chk #(
  parameter int NREQ = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NREQ-1:0] i_push,
  input  logic [NREQ-1:0] i_full
);
  a_no_push_full: assert property (@(posedge i_clk) disable iff (i_rst) (i_push & i_full) == '0);
endmodule

module fpu_issue_arb #(
  parameter int NREQ   = 4,
  parameter int LAT    = 2,
  parameter int RDEPTH = 2
) (
  input  logic                 ACLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [16*NREQ-1:0]   req_ex1,
  input  logic [16*NREQ-1:0]   req_ex2,
  input  logic [16*NREQ-1:0]   req_ex3,
  output logic [1:0]           fpu_op,
  output logic [15:0]          fpu_ex1,
  output logic [15:0]          fpu_ex2,
  output logic [15:0]          fpu_ex3,
  output logic                 fpu_force0,
  input  logic [15:0]          fpu_exd,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [16*NREQ-1:0]   rsp_data,
  output logic [3:0]           inflight
);
  localparam int              PW       = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;
  localparam logic [2:0]      DEPTH3   = 3'(RDEPTH);
  localparam logic [2:0]      LAST_ID  = 3'(NREQ - 1);
  localparam logic [PW-1:0]   LAST_PTR = PW'(RDEPTH - 1);

  logic [2:0]      r_ptr;
  logic            r_rst_d;
  logic [LAT-1:0]  r_tag_v;
  logic [2:0]      r_tag_id [LAT];
  logic [3:0]      r_inflight;
  logic [2:0]      r_credit [NREQ];
  logic [2:0]      r_count  [NREQ];
  logic [PW-1:0]   r_wptr   [NREQ];
  logic [PW-1:0]   r_rptr   [NREQ];
  logic [15:0]     r_mem    [NREQ][RDEPTH];

  logic            w_block;
  logic [NREQ-1:0] w_elig;
  logic            w_grant_any;
  logic [2:0]      w_gid;
  logic [NREQ-1:0] w_grant;
  logic [NREQ-1:0] w_push;
  logic [NREQ-1:0] w_pop;
  logic [NREQ-1:0] w_full;
  logic [3:0]      w_infl_nxt;

  // Grants are suppressed during reset and the cycle after it.
  assign w_block   = RST | r_rst_d;
  assign req_ready = w_grant;
  assign inflight  = r_inflight;

  // Eligibility: pending op and at least one free response slot
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_elig[i] = req_valid[i] & (r_credit[i] != 3'd0) & ~w_block;
    end
  end

  // Round-robin pick: first eligible index starting at r_ptr
  always_comb begin
    int idx;
    idx         = 0;
    w_grant_any = 1'b0;
    w_gid       = 3'd0;
    for (int k = 0; k < NREQ; k++) begin
      idx         = (int'(r_ptr) + k >= NREQ) ? int'(r_ptr) + k - NREQ : int'(r_ptr) + k;
      w_gid       = (!w_grant_any && w_elig[idx]) ? 3'(idx) : w_gid;
      w_grant_any = w_grant_any | w_elig[idx];
    end
    w_grant = w_grant_any ? (NREQ'(1) << w_gid) : '0;
  end

  // FPU operand mux; idle cycles force the pipeline to zero
  always_comb begin
    fpu_op     = 2'd0;
    fpu_ex1    = 16'h0000;
    fpu_ex2    = 16'h0000;
    fpu_ex3    = 16'h0000;
    fpu_force0 = 1'b1;
    if (w_grant_any) begin
      fpu_op     = req_op[{w_gid, 1'b0} +: 2];
      fpu_ex1    = req_ex1[{w_gid, 4'h0} +: 16];
      fpu_ex2    = req_ex2[{w_gid, 4'h0} +: 16];
      fpu_ex3    = req_ex3[{w_gid, 4'h0} +: 16];
      fpu_force0 = 1'b0;
    end else begin
      fpu_force0 = 1'b1;
    end
  end

  // Response-side decode and next in-flight count
  always_comb begin
    rsp_valid  = '0;
    rsp_data   = '0;
    w_push     = '0;
    w_pop      = '0;
    w_full     = '0;
    w_infl_nxt = {3'b000, w_grant_any};
    for (int k = 0; k < LAT - 1; k++) begin
      w_infl_nxt = w_infl_nxt + {3'b000, r_tag_v[k]};
    end
    for (int i = 0; i < NREQ; i++) begin
      w_push[i]            = r_tag_v[LAT-1] & (r_tag_id[LAT-1] == 3'(i));
      w_full[i]            = (r_count[i] == DEPTH3);
      rsp_valid[i]         = (r_count[i] != 3'd0) & ~w_block;
      w_pop[i]             = rsp_valid[i] & rsp_ready[i];
      rsp_data[16*i +: 16] = r_mem[i][r_rptr[i]];
    end
  end

  // Arbiter pointer, tag pipe and in-flight counter
  always_ff @(posedge ACLK) begin
    r_rst_d <= RST;
    if (RST) begin
      r_ptr      <= 3'd0;
      r_tag_v    <= '0;
      r_inflight <= 4'd0;
      for (int k = 0; k < LAT; k++) begin
        r_tag_id[k] <= 3'd0;
      end
    end else begin
      if (w_grant_any) begin
        r_ptr <= (w_gid == LAST_ID) ? 3'd0 : w_gid + 3'd1;
      end else begin
        r_ptr <= r_ptr;
      end
      r_tag_v[0]  <= w_grant_any;
      r_tag_id[0] <= w_gid;
      for (int k = 1; k < LAT; k++) begin
        r_tag_v[k]  <= r_tag_v[k-1];
        r_tag_id[k] <= r_tag_id[k-1];
      end
      r_inflight <= w_infl_nxt;
    end
  end

  // Credits and FIFO occupancy/pointers per requester
  always_ff @(posedge ACLK) begin
    for (int i = 0; i < NREQ; i++) begin
      if (RST) begin
        r_credit[i] <= DEPTH3;
        r_count[i]  <= 3'd0;
        r_wptr[i]   <= '0;
        r_rptr[i]   <= '0;
      end else begin
        case ({w_grant[i], w_pop[i]})
          2'b10:   r_credit[i] <= r_credit[i] - 3'd1;
          2'b01:   r_credit[i] <= r_credit[i] + 3'd1;
          default: r_credit[i] <= r_credit[i];
        endcase
        case ({w_push[i], w_pop[i]})
          2'b10:   r_count[i] <= r_count[i] + 3'd1;
          2'b01:   r_count[i] <= r_count[i] - 3'd1;
          default: r_count[i] <= r_count[i];
        endcase
        if (w_push[i]) begin
          r_wptr[i] <= (r_wptr[i] == LAST_PTR) ? '0 : r_wptr[i] + PW'(1);
        end else begin
          r_wptr[i] <= r_wptr[i];
        end
        if (w_pop[i]) begin
          r_rptr[i] <= (r_rptr[i] == LAST_PTR) ? '0 : r_rptr[i] + PW'(1);
        end else begin
          r_rptr[i] <= r_rptr[i];
        end
      end
    end
  end

  // FIFO storage; stale entries are harmless since occupancy resets
  always_ff @(posedge ACLK) begin
    for (int i = 0; i < NREQ; i++) begin
      if (w_push[i]) begin
        r_mem[i][r_wptr[i]] <= fpu_exd;
      end
    end
  end

  fpu_issue_arb_chk #(.NREQ(NREQ)) u_chk (
    .i_clk  (ACLK),
    .i_rst  (RST),
    .i_push (w_push),
    .i_full (w_full)
  );
endmodule
